req_scan_locator: RTL and testbench

Sequential companion to the flat request-aggregation logic. That logic collapses a large bank of group-gated request lines into one "any request" flag. This block works the other way. It holds the same banked request vector, walks the enabled groups round-robin, and returns the index of each asserted line over a valid/ready handshake. It then issues a one-cycle clear strobe for the line it returned. It sits between the request bank and the service controller that consumes line indices.

---
 rtl/req_scan_locator.sv | 109 ++++++++++
 tb/tb_req_scan_locator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/req_scan_locator.sv
// req_scan_locator: round-robin locator that returns indices of asserted, group-enabled request lines
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   req, grp_en       banked level requests (bit g*WIDTH+b) and per-group enables
//   summary           registered OR of all enabled requests
//   out_valid/ready   located index {group, line} handshake on out_index
//   clr_valid/index   one-cycle clear strobe for the accepted line
//   overrun           sticky flag, a serviced line stayed high past HOLD_CYC
//   REQ_SCAN_SYNC_EN  when defined, req passes a 2-flop synchronizer before req_q
module req_scan_locator #(
   parameter int GROUPS = 8,
   parameter int WIDTH = 32,
   parameter int HOLD_CYC = 15,
   localparam int GW = $clog2(GROUPS),
   localparam int LW = $clog2(WIDTH),
   localparam int IW = GW + LW,
   localparam int N = GROUPS * WIDTH
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic [GROUPS-1:0] grp_en,
   output logic          summary,
   output logic          out_valid,
   output logic [IW-1:0] out_index,
   input  logic          out_ready,
   output logic          clr_valid,
   output logic [IW-1:0] clr_index,
   output logic          overrun
);
   localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, PRESENT = 2'd2, HOLD = 2'd3;
   logic [1:0] state;
   logic [N-1:0] req_q, en_mask, pending;
   logic [GW-1:0] grp_ptr, rr_ptr, scan_cnt;
   logic [7:0] hold_cnt;
   logic [WIDTH-1:0] grp_bits;
   logic [LW-1:0] low;
   logic hit;
`ifdef REQ_SCAN_SYNC_EN
   logic [N-1:0] req_s1, req_s2;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         req_s1 <= '0;
         req_s2 <= '0;
         req_q <= '0;
      end else begin
         req_s1 <= req;
         req_s2 <= req_s1;
         req_q <= req_s2;
      end
`else
   always_ff @(posedge clock or posedge reset)
      if (reset) req_q <= '0;
      else req_q <= req;
`endif
   for (genvar g = 0; g < GROUPS; g++) assign en_mask[g*WIDTH +: WIDTH] = {WIDTH{grp_en[g]}};
   assign pending = req_q & en_mask;
   assign out_valid = state == PRESENT;
   // Lowest set line of the group under the scan pointer wins.
   always_comb begin
      grp_bits = WIDTH'(pending >> {grp_ptr, {LW{1'b0}}});
      hit = |grp_bits;
      low = '0;
      for (int i = WIDTH - 1; i >= 0; i--) if (grp_bits[i]) low = LW'(i);
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         summary <= 1'b0;
         out_index <= '0;
         clr_valid <= 1'b0;
         clr_index <= '0;
         overrun <= 1'b0;
         grp_ptr <= '0;
         rr_ptr <= '0;
         scan_cnt <= '0;
         hold_cnt <= '0;
      end else begin
         summary <= |pending;
         clr_valid <= 1'b0;
         case (state)
            IDLE: if (|pending) begin
               state <= SCAN;
               grp_ptr <= rr_ptr;
               scan_cnt <= '0;
            end
            SCAN: if (hit) begin
               out_index <= {grp_ptr, low};
               state <= PRESENT;
            end else begin
               grp_ptr <= grp_ptr + 1'b1;
               scan_cnt <= scan_cnt + 1'b1;
               if (scan_cnt == GW'(GROUPS - 1)) state <= IDLE;
            end
            PRESENT: if (out_ready) begin
               clr_valid <= 1'b1;
               clr_index <= out_index;
               rr_ptr <= grp_ptr + 1'b1;
               hold_cnt <= '0;
               state <= HOLD;
            end
            HOLD: if (!pending[clr_index]) state <= IDLE;
               else if (hold_cnt == 8'(HOLD_CYC)) begin
                  overrun <= 1'b1;
                  state <= IDLE;
               end else hold_cnt <= hold_cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_req_scan_locator.sv
// tb_req_scan_locator: directed self-checking bench for req_scan_locator
module tb_req_scan_locator;
   logic clock = 1'b0, reset = 1'b1;
   logic [255:0] req = '0;
   logic [7:0] grp_en = 8'hFF;
   logic summary, out_valid, clr_valid, overrun, out_ready = 1'b1;
   logic [7:0] out_index, clr_index;
   int checks = 0, errors = 0;
   req_scan_locator dut (
      .clock(clock), .reset(reset), .req(req), .grp_en(grp_en), .summary(summary),
      .out_valid(out_valid), .out_index(out_index), .out_ready(out_ready),
      .clr_valid(clr_valid), .clr_index(clr_index), .overrun(overrun)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask
   task automatic wait_valid(input string tag, input logic [7:0] exp);
      int n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      check({tag, " valid"}, out_valid, 1);
      check({tag, " index"}, out_index, exp);
   endtask
   task automatic serve(input string tag, input logic [7:0] exp, input int b);
      wait_valid(tag, exp);
      tick();
      check({tag, " clr"}, clr_valid, 1);
      check({tag, " clr_index"}, clr_index, exp);
      req[b] = 1'b0;
   endtask
   initial begin
      logic bad;
      #2;
      check("rst summary", summary, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_index", out_index, 0);
      check("rst clr_valid", clr_valid, 0);
      check("rst clr_index", clr_index, 0);
      check("rst overrun", overrun, 0);
      tick();
      reset = 1'b0;
      tick();
      // single request, group 0 skipped
      req[37] = 1'b1;
      tick();
      check("t1 summary k", summary, 0);
      tick();
      check("t1 summary k+1", summary, 1);
      check("t1 valid k+1", out_valid, 0);
      tick();
      check("t1 valid k+2", out_valid, 0);
      tick();
      check("t1 valid k+3", out_valid, 1);
      check("t1 index", out_index, 8'h25);
      check("t1 clr early", clr_valid, 0);
      tick();
      check("t1 clr", clr_valid, 1);
      check("t1 clr_index", clr_index, 8'h25);
      check("t1 valid after", out_valid, 0);
      req[37] = 1'b0;
      tick();
      check("t1 clr one cycle", clr_valid, 0);
      repeat (3) tick();
      check("t1 summary low", summary, 0);
      // round robin across groups 0, 1, 6
      do_reset();
      req[3] = 1'b1;
      req[40] = 1'b1;
      req[200] = 1'b1;
      serve("t2 a", 8'h03, 3);
      serve("t2 b", 8'h28, 40);
      serve("t2 c", 8'hC8, 200);
      bad = 1'b0;
      repeat (10) begin
         tick();
         bad |= out_valid;
      end
      check("t2 idle valid", bad, 0);
      check("t2 idle summary", summary, 0);
      // disabled group is masked
      do_reset();
      grp_en = 8'hFB;
      req[70] = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         tick();
         bad |= out_valid | summary;
      end
      check("t3 masked", bad, 0);
      grp_en = 8'hFF;
      serve("t3 enabled", 8'h46, 70);
      repeat (4) tick();
      // stall with the line withdrawn mid-PRESENT
      out_ready = 1'b0;
      req[9] = 1'b1;
      wait_valid("t4", 8'h09);
      req[9] = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         tick();
         bad |= !out_valid | (out_index != 8'h09);
      end
      check("t4 held", bad, 0);
      out_ready = 1'b1;
      tick();
      check("t4 clr", clr_valid, 1);
      check("t4 clr_index", clr_index, 8'h09);
      repeat (4) tick();
      // line stuck high after clear
      req[12] = 1'b1;
      wait_valid("t5", 8'h0C);
      tick();
      check("t5 clr", clr_valid, 1);
      repeat (10) tick();
      check("t5 overrun early", overrun, 0);
      begin
         int n = 0;
         while (!overrun && n < 40) begin
            tick();
            n++;
         end
      end
      check("t5 overrun", overrun, 1);
      wait_valid("t5 reissue", 8'h0C);
      req[12] = 1'b0;
      repeat (4) tick();
      check("t5 overrun sticky", overrun, 1);
      // reset during PRESENT
      do_reset();
      out_ready = 1'b0;
      req[12] = 1'b1;
      wait_valid("t6", 8'h0C);
      #2;
      reset = 1'b1;
      out_ready = 1'b1;
      #1;
      check("t6 valid drop", out_valid, 0);
      check("t6 overrun", overrun, 0);
      req[12] = 1'b0;
      tick();
      check("t6 no clr", clr_valid, 0);
      reset = 1'b0;
      bad = 1'b0;
      repeat (5) begin
         tick();
         bad |= clr_valid | out_valid;
      end
      check("t6 quiet", bad, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
